// File: rtl/calc_result_formatter.sv
// Signed binary result -> ASCII decimal character stream using a bit-serial double-dabble engine.
// Define FMT_NEWLINE_EN to append a trailing 8'h0A that carries out_last.
module calc_result_formatter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    function automatic int unsigned calc_digits(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = 64'd1 << w;
        n = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n++;
            end
        end
        return n;
    endfunction

    localparam int unsigned DIGITS = calc_digits(WIDTH);
    localparam int unsigned BCDW   = 4 * DIGITS;
    localparam int unsigned IDXW   = $clog2(DIGITS);
    localparam int unsigned CNTW   = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_SIGN,
        S_DIGITS
`ifdef FMT_NEWLINE_EN
        , S_NL
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BCDW-1:0]  bcd_q, bcd_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic [BCDW-1:0]  bcd_adj;
    logic [BCDW-1:0]  bcd_shift;
    logic [WIDTH-1:0] mag_shift;
    logic [IDXW-1:0]  msd;

    function automatic logic [7:0] digit_char(input logic [BCDW-1:0] b,
                                              input logic [IDXW-1:0] i);
        return {4'h3, b[4*i +: 4]};
    endfunction

    function automatic logic digit_last(input logic [IDXW-1:0] i);
`ifdef FMT_NEWLINE_EN
        return (i != i);
`else
        return (i == '0);
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_shift, mag_shift} = {bcd_adj, mag_q} << 1;

        // Leading-digit search runs on the post-shift value so the first
        // character can be registered on the final conversion edge.
        msd = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_shift[4*i +: 4] != 4'd0) begin
                msd = IDXW'(i);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    neg_d   = in_result[WIDTH-1];
                    mag_d   = in_result[WIDTH-1] ? (~in_result + WIDTH'(1)) : in_result;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d = bcd_shift;
                mag_d = mag_shift;
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    idx_d       = msd;
                    out_valid_d = 1'b1;
                    if (neg_q) begin
                        state_d    = S_SIGN;
                        out_data_d = 8'h2D;
                        out_last_d = 1'b0;
                    end else begin
                        state_d    = S_DIGITS;
                        out_data_d = digit_char(bcd_shift, msd);
                        out_last_d = digit_last(msd);
                    end
                end
            end
            S_SIGN: begin
                if (out_ready) begin
                    state_d    = S_DIGITS;
                    out_data_d = digit_char(bcd_q, idx_q);
                    out_last_d = digit_last(idx_q);
                end
            end
            S_DIGITS: begin
                if (out_ready) begin
                    if (idx_q == '0) begin
`ifdef FMT_NEWLINE_EN
                        state_d    = S_NL;
                        out_data_d = 8'h0A;
                        out_last_d = 1'b1;
`else
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
`endif
                    end else begin
                        idx_d      = idx_q - IDXW'(1);
                        out_data_d = digit_char(bcd_q, idx_q - IDXW'(1));
                        out_last_d = digit_last(idx_q - IDXW'(1));
                    end
                end
            end
`ifdef FMT_NEWLINE_EN
            S_NL: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_calc_result_formatter.sv
// Directed bench for calc_result_formatter (WIDTH=32); honours FMT_NEWLINE_EN when defined.
module tb_calc_result_formatter;

    logic        clk;
    logic        rst;
    logic [31:0] in_result;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    calc_result_formatter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_result (in_result),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_number(input logic [31:0] val, input string base,
                              input bit rnd, input bit hold, input int abort_after);
        string exp;
        int    n;
        int    k;
        int    cyc;
        exp = base;
`ifdef FMT_NEWLINE_EN
        if (abort_after < 0) exp = {base, "\n"};
`endif
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);

        in_result = val;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        if (hold) in_result = 32'd999;
        else      in_valid  = 1'b0;
        check("in_ready_busy", 32'(in_ready), 32'd0);

        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'd32);

        k   = 0;
        cyc = 0;
        while (k < exp.len() && cyc < 400) begin
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(out_data), 32'(exp[k]));
            check("stream_last", 32'(out_last), 32'(k == exp.len() - 1));
            check("stream_in_ready", 32'(in_ready), 32'd0);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (out_ready) k++;
            if (k == abort_after) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                in_valid = 1'b0;
                check("abort_valid", 32'(out_valid), 32'd0);
                check("abort_in_ready", 32'(in_ready), 32'd1);
                check("abort_last", 32'(out_last), 32'd0);
                out_ready = 1'b1;
                return;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_len", 32'(k), 32'(exp.len()));
        check("end_valid", 32'(out_valid), 32'd0);
        check("end_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_result = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        run_number(32'd0,        "0",           1'b0, 1'b0, -1);
        run_number(32'd1234,     "1234",        1'b0, 1'b0, -1);
        run_number(32'hFFFFFFF9, "-7",          1'b0, 1'b0, -1);
        run_number(32'h80000000, "-2147483648", 1'b0, 1'b0, -1);
        run_number(32'h7FFFFFFF, "2147483647",  1'b0, 1'b0, -1);
        run_number(32'd905,      "905",         1'b1, 1'b0, -1);
        run_number(32'd905,      "905",         1'b1, 1'b0, -1);
        run_number(32'd300,      "300",         1'b0, 1'b1, -1);
        run_number(32'h80000000, "-2147483648", 1'b0, 1'b0, 2);
        run_number(32'd42,       "42",          1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
